// File: rtl/uart_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module : uart_pkg
//  Brief  : Shared definitions for the UART receive path: receiver state
//           encoding, data-bit count and the half-bit counter reload helper.
//           Optional macro UART_RX_PARITY_EN adds the PARITY state (8E1).
//  Rev    : 1.0  initial release
// ============================================================================
package uart_pkg;

  // Data bits per UART character
  localparam int UART_DATA_BITS = 8;

  // Receiver FSM states; PARITY exists only when parity checking is built in
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } uart_state_e;

  // Counter reload that lands the first sample in the middle of the start bit
  function automatic int unsigned half_bit_reload(input int unsigned clks_per_bit);
    return (clks_per_bit / 2) - 1;
  endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rx_byte.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module : uart_rx_byte
//  Brief  : rx synchroniser plus UART character deframer. Emits each good
//           byte with a pulse on byte_valid_o, and pulses frame_err_o on a
//           low stop bit (or an even-parity mismatch when UART_RX_PARITY_EN
//           is defined). A low stop bit parks the FSM in BREAK until the
//           line returns high. ce_i low freezes every flop, pulses included.
//  Rev    : 1.0  initial release
// ============================================================================
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ce_i,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(UART_DATA_BITS);

  localparam logic [CNT_W-1:0] FULL_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(half_bit_reload(CLKS_PER_BIT));
  localparam logic [BIT_W-1:0] LAST_BIT    = BIT_W'(UART_DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
  localparam uart_state_e AFTER_DATA = ST_PARITY;
`else
  localparam uart_state_e AFTER_DATA = ST_STOP;
`endif

  logic             sync1_q;
  logic             rxs_q;
  uart_state_e      state_q;
  logic [CNT_W-1:0] baud_q;
  logic [BIT_W-1:0] bit_cnt_q;
  logic [7:0]       shift_q;
  logic [7:0]       byte_q;
  logic             byte_valid_q;
  logic             frame_err_q;
  logic             baud_expired;
  logic             parity_bad;

  assign baud_expired = (baud_q == '0);

`ifdef UART_RX_PARITY_EN
  logic parity_err_q;
  assign parity_bad = parity_err_q;
`else
  assign parity_bad = 1'b0;
`endif

  // Two-flop synchroniser; both flops idle high so reset never looks like a start bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else if (ce_i) begin
      sync1_q <= rx_i;
      rxs_q   <= sync1_q;
    end
  end

  // Deframing FSM: mid-bit sampling, LSB-first shift, registered byte/pulse outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      baud_q       <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      byte_q       <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else if (ce_i) begin
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!rxs_q) begin
            state_q <= ST_START;
            baud_q  <= HALF_RELOAD;
          end
        end

        ST_START: begin
          if (baud_expired) begin
            if (rxs_q) begin
              // Line is back high at mid start bit: a glitch, not a frame
              state_q <= ST_IDLE;
            end else begin
              state_q   <= ST_DATA;
              baud_q    <= FULL_RELOAD;
              bit_cnt_q <= '0;
`ifdef UART_RX_PARITY_EN
              parity_err_q <= 1'b0;
`endif
            end
          end else begin
            baud_q <= baud_q - CNT_W'(1);
          end
        end

        ST_DATA: begin
          if (baud_expired) begin
            baud_q  <= FULL_RELOAD;
            shift_q <= {rxs_q, shift_q[7:1]};
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_q <= '0;
              state_q   <= AFTER_DATA;
            end else begin
              bit_cnt_q <= bit_cnt_q + BIT_W'(1);
            end
          end else begin
            baud_q <= baud_q - CNT_W'(1);
          end
        end

`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (baud_expired) begin
            baud_q       <= FULL_RELOAD;
            // Even parity: data bits plus parity bit must hold an even count of ones
            parity_err_q <= ^{shift_q, rxs_q};
            state_q      <= ST_STOP;
          end else begin
            baud_q <= baud_q - CNT_W'(1);
          end
        end
`endif

        ST_STOP: begin
          if (baud_expired) begin
            baud_q <= FULL_RELOAD;
            if (rxs_q) begin
              state_q <= ST_IDLE;
              if (parity_bad) begin
                frame_err_q <= 1'b1;
              end else begin
                byte_q       <= shift_q;
                byte_valid_q <= 1'b1;
              end
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= ST_BREAK;
            end
          end else begin
            baud_q <= baud_q - CNT_W'(1);
          end
        end

        ST_BREAK: begin
          if (rxs_q) begin
            state_q <= ST_IDLE;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign byte_o       = byte_q;
  assign byte_valid_o = byte_valid_q;
  assign frame_err_o  = frame_err_q;

endmodule : uart_rx_byte
`default_nettype wire

// File: rtl/uart_rx_word.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module : uart_rx_word
//  Brief  : Boot-loader serial front end. Receives UART bytes, pairs them
//           into 16-bit words (first byte in the high half) and offers each
//           word on a valid/ready handshake. frame_err pulses on a bad frame
//           (and drops any half-assembled word); overrun pulses when a word
//           completes while the previous one is still unaccepted (the new
//           word is dropped). Optional macro UART_RX_PARITY_EN selects 8E1.
//  Rev    : 1.0  initial release
// ============================================================================
module uart_rx_word
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int WORD_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ce,
  input  logic                  rx,
  output logic [WORD_WIDTH-1:0] word_data,
  output logic                  word_valid,
  input  logic                  word_ready,
  output logic                  frame_err,
  output logic                  overrun
);

  logic [7:0]            rx_byte;
  logic                  rx_byte_valid;
  logic                  rx_frame_err;
  logic                  handshake;

  logic [7:0]            hi_q,        hi_d;
  logic                  pending_q,   pending_d;
  logic [WORD_WIDTH-1:0] word_data_q, word_data_d;
  logic                  valid_q,     valid_d;
  logic                  overrun_q,   overrun_d;

  uart_rx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx_byte (
    .clk          (clk),
    .rst_n        (rst_n),
    .ce_i         (ce),
    .rx_i         (rx),
    .byte_o       (rx_byte),
    .byte_valid_o (rx_byte_valid),
    .frame_err_o  (rx_frame_err)
  );

  // ce gates the register update below, so it is implied here
  assign handshake = valid_q & word_ready;

  // Byte pairing and output slot next-state
  always_comb begin
    hi_d        = hi_q;
    pending_d   = pending_q;
    word_data_d = word_data_q;
    valid_d     = valid_q;
    overrun_d   = 1'b0;

    if (handshake) begin
      valid_d = 1'b0;
    end

    if (rx_frame_err) begin
      // A bad frame invalidates any half word already collected
      pending_d = 1'b0;
    end else if (rx_byte_valid) begin
      if (!pending_q) begin
        hi_d      = rx_byte;
        pending_d = 1'b1;
      end else begin
        pending_d = 1'b0;
        if (!valid_q || handshake) begin
          word_data_d = {hi_q, rx_byte};
          valid_d     = 1'b1;
        end else begin
          // Held word has priority; the new one is lost
          overrun_d = 1'b1;
        end
      end
    end
  end

  // Word assembly and output registers; everything holds while ce is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q        <= '0;
      pending_q   <= 1'b0;
      word_data_q <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else if (ce) begin
      hi_q        <= hi_d;
      pending_q   <= pending_d;
      word_data_q <= word_data_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign word_data  = word_data_q;
  assign word_valid = valid_q;
  assign overrun    = overrun_q;
  assign frame_err  = rx_frame_err;

endmodule : uart_rx_word
`default_nettype wire

// File: tb/tb_uart_rx_word.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module : tb_uart_rx_word
//  Brief  : Directed self-checking bench for uart_rx_word at CLKS_PER_BIT=4.
//           Define UART_RX_PARITY_EN to build and exercise the 8E1 variant.
//  Rev    : 1.0  initial release
// ============================================================================
module tb_uart_rx_word;

  localparam int CPB = 4;

  logic        clk        = 1'b0;
  logic        rst_n      = 1'b0;
  logic        ce         = 1'b1;
  logic        rx         = 1'b1;
  logic        word_ready = 1'b0;
  logic [15:0] word_data;
  logic        word_valid;
  logic        frame_err;
  logic        overrun;

  int checks   = 0;
  int failures = 0;
  int fe_cnt   = 0;
  int ov_cnt   = 0;
  bit ce_toggle = 1'b0;
  logic [15:0] acc_q[$];

  always #5 clk = ~clk;

  uart_rx_word #(
    .CLKS_PER_BIT (CPB),
    .WORD_WIDTH   (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ce         (ce),
    .rx         (rx),
    .word_data  (word_data),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  // Inputs change just after posedge, so values seen at negedge are those the next edge uses
  always @(negedge clk) begin
    if (rst_n && ce) begin
      if (word_valid && word_ready) acc_q.push_back(word_data);
      if (frame_err) fe_cnt++;
      if (overrun)   ov_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (ce_toggle) ce = ~ce;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (ce_toggle ? 2 * CPB : CPB) tick();
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_bit, input logic flip_par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ flip_par);
`else
    if (flip_par) rx = 1'b1;
`endif
    send_bit(stop_bit);
  endtask

  task automatic accept_word();
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) tick();
    checks++; if (word_data !== 16'h0000) begin failures++; $display("FAIL reset_data: got %h expected %h", word_data, 16'h0000); end
    checks++; if (word_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected %b", word_valid, 1'b0); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err: got %b expected %b", frame_err, 1'b0); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun: got %b expected %b", overrun, 1'b0); end
    rst_n = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b5a;
    b5a = 8'h5A;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(b5a[i]);
    rst_n = 1'b0;
    #1;
    checks++; if (word_valid !== 1'b0) begin failures++; $display("FAIL midframe_reset_valid: got %b expected %b", word_valid, 1'b0); end
    rx = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    send_byte(8'h12, 1'b1, 1'b0);
    send_byte(8'h34, 1'b1, 1'b0);
    tick();
    checks++; if (word_valid !== 1'b0) begin failures++; $display("FAIL latency_early_valid: got %b expected %b", word_valid, 1'b0); end
    tick();
    checks++; if (word_valid !== 1'b1) begin failures++; $display("FAIL latency_valid: got %b expected %b", word_valid, 1'b1); end
    checks++; if (word_data !== 16'h1234) begin failures++; $display("FAIL first_word: got %h expected %h", word_data, 16'h1234); end
    checks++; if (fe_cnt !== 0) begin failures++; $display("FAIL first_word_frame_err: got %0d expected %0d", fe_cnt, 0); end
    accept_word();
    checks++; if (word_valid !== 1'b0) begin failures++; $display("FAIL accept_clears_valid: got %b expected %b", word_valid, 1'b0); end
  endtask

  task automatic test_back_to_back();
    int ov0;
    logic [15:0] w0, w1;
    acc_q.delete();
    ov0 = ov_cnt;
    word_ready = 1'b1;
    send_byte(8'hAB, 1'b1, 1'b0);
    send_byte(8'hCD, 1'b1, 1'b0);
    send_byte(8'hEF, 1'b1, 1'b0);
    send_byte(8'h01, 1'b1, 1'b0);
    repeat (4) tick();
    word_ready = 1'b0;
    w0 = (acc_q.size() > 0) ? acc_q[0] : 16'hxxxx;
    w1 = (acc_q.size() > 1) ? acc_q[1] : 16'hxxxx;
    checks++; if (acc_q.size() !== 2) begin failures++; $display("FAIL b2b_count: got %0d expected %0d", acc_q.size(), 2); end
    checks++; if (w0 !== 16'hABCD) begin failures++; $display("FAIL b2b_word0: got %h expected %h", w0, 16'hABCD); end
    checks++; if (w1 !== 16'hEF01) begin failures++; $display("FAIL b2b_word1: got %h expected %h", w1, 16'hEF01); end
    checks++; if (ov_cnt - ov0 !== 0) begin failures++; $display("FAIL b2b_overrun: got %0d expected %0d", ov_cnt - ov0, 0); end
    checks++; if (word_valid !== 1'b0) begin failures++; $display("FAIL b2b_valid_after: got %b expected %b", word_valid, 1'b0); end
  endtask

  task automatic test_overrun();
    int ov0;
    ov0 = ov_cnt;
    word_ready = 1'b0;
    send_byte(8'h11, 1'b1, 1'b0);
    send_byte(8'h11, 1'b1, 1'b0);
    send_byte(8'h22, 1'b1, 1'b0);
    send_byte(8'h22, 1'b1, 1'b0);
    send_byte(8'h33, 1'b1, 1'b0);
    send_byte(8'h33, 1'b1, 1'b0);
    repeat (3) tick();
    checks++; if (word_data !== 16'h1111) begin failures++; $display("FAIL overrun_held_data: got %h expected %h", word_data, 16'h1111); end
    checks++; if (word_valid !== 1'b1) begin failures++; $display("FAIL overrun_held_valid: got %b expected %b", word_valid, 1'b1); end
    checks++; if (ov_cnt - ov0 !== 2) begin failures++; $display("FAIL overrun_pulses: got %0d expected %0d", ov_cnt - ov0, 2); end
    acc_q.delete();
    accept_word();
    checks++; if (word_valid !== 1'b0) begin failures++; $display("FAIL overrun_accept_valid: got %b expected %b", word_valid, 1'b0); end
    checks++; if (word_data !== 16'h1111) begin failures++; $display("FAIL overrun_data_kept: got %h expected %h", word_data, 16'h1111); end
    checks++; if (acc_q.size() !== 1) begin failures++; $display("FAIL overrun_accept_count: got %0d expected %0d", acc_q.size(), 1); end
  endtask

  task automatic test_break();
    int fe0;
    fe0 = fe_cnt;
    send_byte(8'h77, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (20) tick();
    rx = 1'b1;
    repeat (8) tick();
    checks++; if (fe_cnt - fe0 !== 1) begin failures++; $display("FAIL break_frame_err: got %0d expected %0d", fe_cnt - fe0, 1); end
    checks++; if (word_valid !== 1'b0) begin failures++; $display("FAIL break_no_word: got %b expected %b", word_valid, 1'b0); end
    send_byte(8'h88, 1'b1, 1'b0);
    send_byte(8'h99, 1'b1, 1'b0);
    repeat (3) tick();
    checks++; if (word_valid !== 1'b1) begin failures++; $display("FAIL break_word_valid: got %b expected %b", word_valid, 1'b1); end
    checks++; if (word_data !== 16'h8899) begin failures++; $display("FAIL break_word: got %h expected %h", word_data, 16'h8899); end
    accept_word();
  endtask

  task automatic test_glitch_ce();
    int fe0;
    fe0 = fe_cnt;
    rx = 1'b0;
    tick();
    rx = 1'b1;
    repeat (12) tick();
    checks++; if (fe_cnt - fe0 !== 0) begin failures++; $display("FAIL glitch_frame_err: got %0d expected %0d", fe_cnt - fe0, 0); end
    checks++; if (word_valid !== 1'b0) begin failures++; $display("FAIL glitch_valid: got %b expected %b", word_valid, 1'b0); end
    ce_toggle = 1'b1;
    send_byte(8'h0F, 1'b1, 1'b0);
    send_byte(8'hF0, 1'b1, 1'b0);
    ce_toggle = 1'b0;
    ce = 1'b1;
    repeat (4) tick();
    checks++; if (word_valid !== 1'b1) begin failures++; $display("FAIL ce_word_valid: got %b expected %b", word_valid, 1'b1); end
    checks++; if (word_data !== 16'h0FF0) begin failures++; $display("FAIL ce_word: got %h expected %h", word_data, 16'h0FF0); end
    checks++; if (fe_cnt - fe0 !== 0) begin failures++; $display("FAIL ce_frame_err: got %0d expected %0d", fe_cnt - fe0, 0); end
    accept_word();
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int fe0;
    fe0 = fe_cnt;
    send_byte(8'h03, 1'b1, 1'b1);
    repeat (4) tick();
    checks++; if (fe_cnt - fe0 !== 1) begin failures++; $display("FAIL parity_frame_err: got %0d expected %0d", fe_cnt - fe0, 1); end
    checks++; if (word_valid !== 1'b0) begin failures++; $display("FAIL parity_valid: got %b expected %b", word_valid, 1'b0); end
    send_byte(8'h03, 1'b1, 1'b0);
    send_byte(8'h01, 1'b1, 1'b0);
    repeat (3) tick();
    checks++; if (word_valid !== 1'b1) begin failures++; $display("FAIL parity_word_valid: got %b expected %b", word_valid, 1'b1); end
    checks++; if (word_data !== 16'h0301) begin failures++; $display("FAIL parity_word: got %h expected %h", word_data, 16'h0301); end
    accept_word();
  endtask
`endif

  initial begin
    test_reset();
    test_reset_midframe();
    test_back_to_back();
    test_overrun();
    test_break();
    test_glitch_ce();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_uart_rx_word
`default_nettype wire

// File: doc/uart_rx_word.md
Name: uart_rx_word

Overview:
- Serial front end for the boot loader path.
- Synchronises the rx pin (uio_in[0]) and deframes 8N1 UART bytes.
- Packs byte pairs into 16-bit RAM words, high byte first.
- Presents each word on a valid/ready handshake to the downstream boot loader write stage, with frame-error and overrun flags.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); minimum 4.
- WORD_WIDTH, 16, output word width; fixed at 2 bytes, must be 16.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- ce  input  1  clock enable; when low, all state, counters and outputs hold
- rx  input  1  asynchronous serial line, idle high
- word_data  output  16  assembled word; {first byte, second byte}
- word_valid  output  1  word_data holds an unconsumed word
- word_ready  input  1  downstream accepts the word when high with word_valid, ce high
- frame_err  output  1  one-cycle pulse: bad stop bit, or parity error with option
- overrun  output  1  one-cycle pulse: word completed while a previous word was still unaccepted

Behaviour:
- Reset: one clock; rst_n asynchronous, active-low. All outputs are 0. FSM goes to IDLE, bit and baud counters to 0, hi-byte-pending flag cleared. Both rx synchroniser flops reset to 1.
- rx passes through a 2-flop synchroniser; all decisions use the synchronised value rxs.
- FSM states: IDLE, START, DATA, STOP, BREAK; PARITY is added with the optional feature.
- IDLE: on rxs=0, go to START and load the baud counter with CLKS_PER_BIT/2 - 1.
- START: when the counter expires, sample rxs.
  - rxs=1: false start, return to IDLE.
  - rxs=0: go to DATA; counter reloads with CLKS_PER_BIT-1.
- DATA: sample 8 bits at mid-bit, LSB first, into the shift register. Bit counter runs 0..7, then go to STOP.
- STOP: sample at mid-bit.
  - rxs=1: byte good, go to IDLE the same cycle; a new start edge is accepted from the next cycle.
  - rxs=0: pulse frame_err, discard the byte, clear the hi-byte-pending flag (drops any half word), go to BREAK.
- BREAK: stay until rxs=1, then IDLE.
- Word assembly:
  - First good byte: store in the hi register, set pending.
  - Second good byte: form word {hi, byte}, clear pending.
- Output register, on a word completion:
  - word_valid=0, or a handshake in the same cycle: load word_data, set word_valid the cycle after the stop-bit sample. Latency is 1 cycle after the mid-stop sample.
  - word_valid=1 and no handshake: new word dropped, held word kept, overrun pulses.
- Handshake (word_valid & word_ready & ce) with no completion: word_valid clears next cycle. word_data keeps its last value.
- word_data is stable while word_valid=1 and unaccepted.
- ce low freezes everything, including synchroniser flops and pulses. A pulse raised on a ce=1 cycle stays high until the next ce=1 edge.
- Reset mid-frame: immediate return to reset state. A partial byte or half word is lost.
- Counter width: $clog2(CLKS_PER_BIT). Baud counter counts down and reloads on expiry.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined: frame is 8E1. PARITY state follows DATA and samples the bit at mid-bit.
  - Even-parity mismatch: frame_err pulses and the byte is discarded as for a bad stop. Stop bit is still checked; FSM goes to BREAK only if the stop bit is low, otherwise IDLE.
- Undefined: 8N1; no PARITY state and no parity logic.

Decomposition:
- Shared package uart_pkg: FSM state enum, UART_DATA_BITS=8 localparam, half-bit reload function.
- Sub-module uart_rx_byte: synchroniser + FSM + shift register. Outputs byte, byte_valid pulse, frame_err.
- uart_rx_word: instantiates uart_rx_byte, adds pairing and the output handshake register.

Test Plan (CLKS_PER_BIT=4):
- Reset assertion during DATA of byte 0x5A; release; send 0x12, 0x34 -> word_data=0x1234, word_valid=1 one cycle after the second stop sample; no frame_err.
- word_ready held high; send 0xAB,0xCD then 0xEF,0x01 back-to-back -> two words 0xABCD, 0xEF01, each accepted; overrun stays 0.
- word_ready held low; send three words 0x1111, 0x2222, 0x3333 -> word_data stays 0x1111; overrun pulses twice; then ready=1 -> valid clears next cycle.
- Send 0x77 with stop bit low, hold rx low 20 cycles, release; then send 0x88,0x99 -> frame_err one pulse, FSM in BREAK until rx high, 0x77 dropped, output word 0x8899.
- rx low glitch of 1 cycle while idle -> false start rejected; no byte, no flags. Send 0x0F,0xF0 with ce toggling 50% -> word 0x0FF0 received correctly.
- With UART_RX_PARITY_EN: send 0x03 with parity bit 1 -> frame_err, byte dropped. Then 0x03/p=0 and 0x01/p=1 -> word 0x0301.
